// File: rtl/rca_chk_pkg.sv
// Shared types and helpers for the ripple-carry adder response checker.
package rca_chk_pkg;

  // Checker sequencing: wait for start, consume a full sweep, hold the verdict.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Number of {a,b,cin} combinations in an exhaustive sweep of a width-bit adder.
  function automatic int total_vecs(input int width);
    return 1 << (2 * width + 1);
  endfunction

endpackage

// File: rtl/rca_golden.sv
// Golden reference for the adder under test: full-precision a + b + cin.
// Kept on its own so the reference can be replaced without touching the checker FSM.
module rca_golden #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] exp_s,
  output logic             exp_cout
);

  logic [WIDTH:0] sum;

  // Widen before adding so the carry-out is never lost.
  always_comb begin
    sum               = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    {exp_cout, exp_s} = sum;
  end

endmodule

// File: rtl/rca_resp_checker.sv
// Response checker for an exhaustive ripple-carry adder sweep.
// Handshake: a pair {a,b,cin,s,cout} is accepted on a rising edge where
// in_valid && in_ready; in_ready depends only on registered state (high in RUN)
// and never on in_valid, so the source may hold or drop in_valid freely.
module rca_resp_checker
  import rca_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2 * WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic [WIDTH-1:0]     s,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     seq_err_cnt,
  output logic                 first_err_valid,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic [WIDTH:0]       first_err_got,
  output chk_state_t           dbg_state
);

  localparam int VW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(total_vecs(WIDTH) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             run_ok;

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] seq_err_cnt_q, seq_err_cnt_d;
  logic             fe_valid_q, fe_valid_d;
  logic [VW-1:0]    fe_vec_q, fe_vec_d;
  logic [WIDTH:0]   fe_got_q, fe_got_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] exp_s;
  logic             exp_cout;
  logic [VW-1:0]    vec_in;
  logic [WIDTH:0]   got_res;
  logic             seq_bad;
  logic             res_bad;

  rca_golden #(.WIDTH(WIDTH)) u_golden (
    .a       (a),
    .b       (b),
    .cin     (cin),
    .exp_s   (exp_s),
    .exp_cout(exp_cout)
  );

  // Reset release shifts through two flops; start is ignored until it reaches the end.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    run_ok     = rst_sync_q[1];
  end

  // Per-accept comparisons: arrival order and result correctness.
  always_comb begin
    vec_in  = {a, b, cin};
    got_res = {cout, s};
    seq_bad = (vec_in != vec_cnt_q[VW-1:0]);
    res_bad = (got_res != {exp_cout, exp_s});
  end

  // Next-state and counter update.
  always_comb begin
    state_d       = state_q;
    vec_cnt_d     = vec_cnt_q;
    err_cnt_d     = err_cnt_q;
    seq_err_cnt_d = seq_err_cnt_q;
    fe_valid_d    = fe_valid_q;
    fe_vec_d      = fe_vec_q;
    fe_got_d      = fe_got_q;
    pass_d        = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && run_ok) begin
          state_d       = RUN;
          vec_cnt_d     = '0;
          err_cnt_d     = '0;
          seq_err_cnt_d = '0;
          fe_valid_d    = 1'b0;
          fe_vec_d      = '0;
          fe_got_d      = '0;
          pass_d        = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (seq_bad) seq_err_cnt_d = seq_err_cnt_q + CNT_ONE;
          if (res_bad) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_vec_d   = vec_in;
              fe_got_d   = got_res;
            end
          end
          vec_cnt_d = vec_cnt_q + CNT_ONE;
          // The final vector's own result counts toward the verdict.
          if (vec_cnt_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (err_cnt_d == '0) && (seq_err_cnt_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset-release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Checker state; cleared immediately whenever rst_n goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vec_cnt_q     <= '0;
      err_cnt_q     <= '0;
      seq_err_cnt_q <= '0;
      fe_valid_q    <= 1'b0;
      fe_vec_q      <= '0;
      fe_got_q      <= '0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_cnt_q     <= vec_cnt_d;
      err_cnt_q     <= err_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      fe_valid_q    <= fe_valid_d;
      fe_vec_q      <= fe_vec_d;
      fe_got_q      <= fe_got_d;
      pass_q        <= pass_d;
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    in_ready        = (state_q == RUN);
    busy            = (state_q == RUN);
    done            = (state_q == DONE);
    pass            = pass_q;
    vec_cnt         = vec_cnt_q;
    err_cnt         = err_cnt_q;
    seq_err_cnt     = seq_err_cnt_q;
    first_err_valid = fe_valid_q;
    first_err_vec   = fe_vec_q;
    first_err_got   = fe_got_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_rca_resp_checker.sv
// Bench for rca_resp_checker: table of sweep scenarios plus a reset-abort sequence.
module tb_rca_resp_checker;
  import rca_chk_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2 * WIDTH + 2;
  localparam int TOTAL = 512;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             start, in_valid, in_ready, cin, cout;
  logic [WIDTH-1:0] a, b, s;
  logic             busy, done, pass, first_err_valid;
  logic [CNT_W-1:0] vec_cnt, err_cnt, seq_err_cnt;
  logic [2*WIDTH:0] first_err_vec;
  logic [WIDTH:0]   first_err_got;
  chk_state_t       dbg_state;

  rca_resp_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .seq_err_cnt(seq_err_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .first_err_got(first_err_got), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];   // {vec, got} of every mismatch the model expects, in order
  int m_seq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_vec_cnt"}, 32'(vec_cnt), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_seq_cnt"}, 32'(seq_err_cnt), 0);
    check({tag, "_fe_valid"}, 32'(first_err_valid), 0);
    check({tag, "_fe_vec"}, 32'(first_err_vec), 0);
    check({tag, "_fe_got"}, 32'(first_err_got), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int       fault_vec;     // vector whose sum LSB is flipped, -1 none
    int       swap_idx;      // positions swap_idx and swap_idx+1 exchanged, -1 none
    int       gap_pct;       // percentage of idle in_valid cycles
    int       rand_err_pct;  // percentage of randomly corrupted results
    int       start_at;      // cycle in RUN at which a stray start is pulsed, -1 none
    int       exp_err;       // -1: take from model
    int       exp_seq;       // -1: take from model
    int       exp_pass;      // -1: take from model
    int       chk_first;     // compare first_err_* against the constants below
    logic [8:0] exp_fvec;
    logic [4:0] exp_fgot;
  } scen_t;

  // ---------------- driver ----------------
  // Runs one sweep from start; returns early (at a negedge) once abort_at vectors are accepted.
  task automatic run_sweep(input scen_t sc, input int sid, input int abort_at);
    int ord[TOTAL];
    int idx, cyc, stalls, sum_i, got_i, tmp, e_err, e_seq, e_pass;
    logic [8:0] v9;
    logic       acc;
    string      t;
    t = $sformatf("s%0d", sid);
    for (int i = 0; i < TOTAL; i++) ord[i] = i;
    if (sc.swap_idx >= 0) begin
      tmp = ord[sc.swap_idx]; ord[sc.swap_idx] = ord[sc.swap_idx + 1]; ord[sc.swap_idx + 1] = tmp;
    end
    exp_q.delete();
    m_seq  = 0;
    stalls = 0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({t, "_start_busy"}, 32'(busy), 1);
    check({t, "_start_ready"}, 32'(in_ready), 1);
    check({t, "_start_done"}, 32'(done), 0);
    check({t, "_start_pass"}, 32'(pass), 0);
    check({t, "_start_cnts"}, 32'({vec_cnt, err_cnt, seq_err_cnt}), 0);
    check({t, "_start_fe"}, 32'({first_err_valid, first_err_vec, first_err_got}), 0);

    idx = 0; cyc = 0;
    while (idx < TOTAL && cyc < 4 * TOTAL && idx != abort_at) begin
      if (sc.gap_pct > 0 && int'($urandom_range(99)) < sc.gap_pct) begin
        in_valid = 1'b0;
        {a, b, cin, s, cout} = 15'($urandom);
        got_i = 0; sum_i = 0;
        stalls++;
      end else begin
        v9    = 9'(ord[idx]);
        a     = v9[8:5];
        b     = v9[4:1];
        cin   = v9[0];
        sum_i = int'(a) + int'(b) + int'(cin);
        got_i = sum_i;
        if (ord[idx] == sc.fault_vec) got_i = got_i ^ 1;
        if (sc.rand_err_pct > 0 && int'($urandom_range(99)) < sc.rand_err_pct)
          got_i = got_i ^ int'($urandom_range(1, 31));
        {cout, s} = 5'(got_i);
        in_valid  = 1'b1;
      end
      start = (cyc == sc.start_at);
      acc   = in_valid && in_ready;
      if (acc) begin
        if (ord[idx] != idx) m_seq++;
        if (got_i != sum_i) exp_q.push_back({v9, 5'(got_i)});
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (acc && idx % 128 == 0 && idx < TOTAL) begin
        check($sformatf("%s_mid%0d_vec_cnt", t, idx), 32'(vec_cnt), 32'(idx));
        check($sformatf("%s_mid%0d_err_cnt", t, idx), 32'(err_cnt), 32'(exp_q.size()));
        check($sformatf("%s_mid%0d_seq_cnt", t, idx), 32'(seq_err_cnt), 32'(m_seq));
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx == abort_at) return;
    if (idx < TOTAL) begin
      check({t, "_timeout_accepts"}, 32'(idx), 32'(TOTAL));
      return;
    end

    e_err  = (sc.exp_err  >= 0) ? sc.exp_err  : exp_q.size();
    e_seq  = (sc.exp_seq  >= 0) ? sc.exp_seq  : m_seq;
    e_pass = (sc.exp_pass >= 0) ? sc.exp_pass : int'(exp_q.size() == 0 && m_seq == 0);
    check({t, "_done"}, 32'(done), 1);
    check({t, "_busy"}, 32'(busy), 0);
    check({t, "_in_ready"}, 32'(in_ready), 0);
    check({t, "_pass"}, 32'(pass), 32'(e_pass));
    check({t, "_vec_cnt"}, 32'(vec_cnt), 32'(TOTAL));
    check({t, "_err_cnt"}, 32'(err_cnt), 32'(e_err));
    check({t, "_seq_cnt"}, 32'(seq_err_cnt), 32'(e_seq));
    check({t, "_cycles"}, 32'(cyc), 32'(TOTAL + stalls));
    check({t, "_fe_valid"}, 32'(first_err_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check({t, "_fe_model"}, 32'({first_err_vec, first_err_got}), 32'(exp_q[0]));
    else
      check({t, "_fe_zero"}, 32'({first_err_vec, first_err_got}), 0);
    if (sc.chk_first != 0) begin
      check({t, "_fe_vec"}, 32'(first_err_vec), 32'(sc.exp_fvec));
      check({t, "_fe_got"}, 32'(first_err_got), 32'(sc.exp_fgot));
    end
    // A stall after DONE must leave the verdict untouched.
    repeat (2) @(negedge clk);
    check({t, "_hold_done"}, 32'({done, pass}), 32'({1'b1, e_pass[0]}));
  endtask

  // ---------------- test sequence ----------------
  scen_t tbl[6];
  scen_t ab;

  initial begin
    tbl[0] = '{-1, -1,  0, 0, -1, 0, 0, 1, 0, 9'h0, 5'h0};                 // clean, back-to-back
    tbl[1] = '{37, -1,  0, 0, -1, 1, 0, 0, 1, 9'h025, 5'b00101};           // vector 37 wrong sum
    tbl[2] = '{-1, -1,  0, 0, -1, 0, 0, 1, 0, 9'h0, 5'h0};                 // restart from failing DONE
    tbl[3] = '{-1, 100, 0, 0, -1, 0, 2, 0, 0, 9'h0, 5'h0};                 // 100/101 swapped
    tbl[4] = '{-1, -1, 30, 0, 60, 0, 0, 1, 0, 9'h0, 5'h0};                 // stalls + stray start
    tbl[5] = '{-1, int'($urandom_range(0, TOTAL - 2)), 30, 3, -1, -1, -1, -1, 0, 9'h0, 5'h0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", 32'({busy, done, in_ready}), 0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i], i, -1);

    // Abort a noisy sweep after 200 accepts with an asynchronous reset.
    ab = '{-1, 50, 0, 5, -1, -1, -1, -1, 0, 9'h0, 5'h0};
    run_sweep(ab, 6, 200);
    check("abort_vec_cnt", 32'(vec_cnt), 200);
    #2 rst_n = 1'b0;
    #1 check_cleared("abort_rst");
    @(negedge clk);
    check_cleared("abort_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_sweep(tbl[0], 7, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
